// File: rtl/router_merge_pkg.sv
// rtl/router_merge_pkg.sv - shared constants and selector encoding for router_merge
package router_merge_pkg;

    localparam int DATA_W = 11;
    localparam int CTRL_W = 3;
    localparam int NUM_IN = 5;

    // Selector values 5..7 are reserved and have no enumerator.
    typedef enum logic [CTRL_W-1:0] {
        SEL_IN1 = 3'd0,
        SEL_IN2 = 3'd1,
        SEL_IN3 = 3'd2,
        SEL_IN4 = 3'd3,
        SEL_IN5 = 3'd4
    } sel_t;

    function automatic logic sel_reserved(input logic [CTRL_W-1:0] sel);
        return sel >= CTRL_W'(NUM_IN);
    endfunction

endpackage

// File: rtl/router_merge_outreg.sv
// rtl/router_merge_outreg.sv - single-entry valid/ready output register with load and stall hold
module router_merge_outreg #(
    parameter int W = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Load wins over drain so a same-cycle drain and refill leaves no bubble; data holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/router_merge.sv
// rtl/router_merge.sv - control-steered 5:1 flit merge; ROUTERMERGE_CTRL_ERR_EN adds sticky ctrl_err
module router_merge #(
    parameter int DATA_W = router_merge_pkg::DATA_W,
    parameter int CTRL_W = router_merge_pkg::CTRL_W,
    parameter int NUM_IN = router_merge_pkg::NUM_IN
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in2_data,
    input  logic              in2_valid,
    output logic              in2_ready,
    input  logic [DATA_W-1:0] in3_data,
    input  logic              in3_valid,
    output logic              in3_ready,
    input  logic [DATA_W-1:0] in4_data,
    input  logic              in4_valid,
    output logic              in4_ready,
    input  logic [DATA_W-1:0] in5_data,
    input  logic              in5_valid,
    output logic              in5_ready,
    input  logic [CTRL_W-1:0] ctrl_data,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ROUTERMERGE_CTRL_ERR_EN
    ,
    output logic              ctrl_err
`endif
);

    import router_merge_pkg::*;

    logic              w_reserved;
    logic              w_sel_valid;
    logic [DATA_W-1:0] w_sel_data;
    logic [NUM_IN-1:0] w_sel_onehot;
    logic              w_out_free;
    logic              w_fire;
    logic              w_rsv_take;

    assign w_reserved = (ctrl_data >= CTRL_W'(NUM_IN));

    // Decode the head token into the selected channel's valid, flit and ready position.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_data   = '0;
        w_sel_onehot = '0;
        case (ctrl_data)
            SEL_IN1: begin w_sel_valid = in1_valid; w_sel_data = in1_data; w_sel_onehot = 5'b00001; end
            SEL_IN2: begin w_sel_valid = in2_valid; w_sel_data = in2_data; w_sel_onehot = 5'b00010; end
            SEL_IN3: begin w_sel_valid = in3_valid; w_sel_data = in3_data; w_sel_onehot = 5'b00100; end
            SEL_IN4: begin w_sel_valid = in4_valid; w_sel_data = in4_data; w_sel_onehot = 5'b01000; end
            SEL_IN5: begin w_sel_valid = in5_valid; w_sel_data = in5_data; w_sel_onehot = 5'b10000; end
            default: ;
        endcase
    end

    // Reserved tokens drain regardless of output state; RESET blocks every handshake.
    assign w_out_free = !out_valid || out_ready;
    assign w_fire     = !RESET && ctrl_valid && !w_reserved && w_sel_valid && w_out_free;
    assign w_rsv_take = !RESET && ctrl_valid && w_reserved;
    assign ctrl_ready = w_fire || w_rsv_take;

    assign {in5_ready, in4_ready, in3_ready, in2_ready, in1_ready} =
        w_fire ? w_sel_onehot : '0;

    router_merge_outreg #(
        .W (DATA_W)
    ) u_outreg (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_load  (w_fire),
        .i_data  (w_sel_data),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data)
    );

`ifdef ROUTERMERGE_CTRL_ERR_EN
    logic r_ctrl_err;

    // Sticky flag raised once any reserved selector has been consumed; cleared only by RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ctrl_err <= 1'b0;
        end else if (w_rsv_take) begin
            r_ctrl_err <= 1'b1;
        end
    end

    assign ctrl_err = r_ctrl_err;
`endif

endmodule

// File: tb/tb_router_merge.sv
// tb/tb_router_merge.sv - randomized and directed bench for router_merge with scoreboard
module tb_router_merge;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [10:0] in_d [5];
    logic [4:0]  in_v;
    logic        in1_ready, in2_ready, in3_ready, in4_ready, in5_ready;
    logic [4:0]  in_r;
    logic [2:0]  cd;
    logic        cv;
    logic        ctrl_ready;
    logic [10:0] out_data;
    logic        out_valid;
    logic        ordy;
`ifdef ROUTERMERGE_CTRL_ERR_EN
    logic        ctrl_err;
`endif

    assign in_r = {in5_ready, in4_ready, in3_ready, in2_ready, in1_ready};

    router_merge dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in1_data   (in_d[0]),
        .in1_valid  (in_v[0]),
        .in1_ready  (in1_ready),
        .in2_data   (in_d[1]),
        .in2_valid  (in_v[1]),
        .in2_ready  (in2_ready),
        .in3_data   (in_d[2]),
        .in3_valid  (in_v[2]),
        .in3_ready  (in3_ready),
        .in4_data   (in_d[3]),
        .in4_valid  (in_v[3]),
        .in4_ready  (in4_ready),
        .in5_data   (in_d[4]),
        .in5_valid  (in_v[4]),
        .in5_ready  (in5_ready),
        .ctrl_data  (cd),
        .ctrl_valid (cv),
        .ctrl_ready (ctrl_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (ordy)
`ifdef ROUTERMERGE_CTRL_ERR_EN
        ,
        .ctrl_err   (ctrl_err)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    logic        m_valid;
    logic [10:0] m_data;
    logic        m_err;
    logic        sb_on;
    logic [10:0] sb [$];
    logic        last_cr;
    logic [4:0]  last_ir;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare against model at the falling edge, then advance model at the rising edge.
    task automatic step(output logic cfire, output logic [4:0] ifire);
        logic       rsv, selv, free, exp_cr;
        logic [4:0] exp_ir;
        @(negedge CLK);
        #1;
        rsv    = (cd >= 3'd5);
        selv   = rsv ? 1'b0 : in_v[cd];
        free   = !m_valid || ordy;
        exp_cr = cv && (rsv || (selv && free));
        exp_ir = (cv && !rsv && selv && free) ? (5'b00001 << cd) : 5'b00000;
        chk("ctrl_ready", ctrl_ready, exp_cr);
        chk("in_ready", in_r, exp_ir);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) chk("out_data", out_data, m_data);
`ifdef ROUTERMERGE_CTRL_ERR_EN
        chk("ctrl_err", ctrl_err, m_err);
`endif
        last_cr = ctrl_ready;
        last_ir = in_r;
        if (sb_on && out_valid && ordy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard unexpected flit actual=%0h required=none", out_data);
            end else begin
                chk("scoreboard", out_data, sb.pop_front());
            end
        end
        @(posedge CLK);
        if (exp_ir != 5'b0) begin
            m_valid = 1'b1;
            m_data  = in_d[cd];
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (cv && rsv) m_err = 1'b1;
        cfire = exp_cr;
        ifire = exp_ir;
        #1;
    endtask

    initial begin
        logic       cf;
        logic [4:0] ifr;
        int         pulses [5];
        int         tok [1000];
        int         cnt [5];
        int         idx;
        int         cycles;

        RESET = 1'b1; cv = 1'b1; cd = 3'd0; in_v = 5'h1f; ordy = 1'b0;
        for (int n = 0; n < 5; n++) in_d[n] = 11'(10 * (n + 1));
        m_valid = 1'b0; m_data = '0; m_err = 1'b0; sb_on = 1'b0;
        last_cr = 1'b0; last_ir = '0;

        // Reset state, with all valids asserted.
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ctrl_ready", ctrl_ready, 0);
        chk("rst_in_ready", in_r, 0);
`ifdef ROUTERMERGE_CTRL_ERR_EN
        chk("rst_ctrl_err", ctrl_err, 0);
`endif
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // In-order sequence 0..4 at full throughput.
        ordy = 1'b1;
        for (int n = 0; n < 5; n++) pulses[n] = 0;
        for (int k = 0; k < 5; k++) begin
            cd = 3'(k);
            step(cf, ifr);
            for (int n = 0; n < 5; n++) pulses[n] += int'(last_ir[n]);
            chk("seq_out_data", out_data, 11'(10 * (k + 1)));
            chk("seq_out_valid", out_valid, 1);
        end
        for (int n = 0; n < 5; n++) chk("seq_ready_pulses", pulses[n], 1);
        cv = 1'b0;
        step(cf, ifr);

        // Stalled selected input.
        cv = 1'b1; cd = 3'd2; in_v = 5'b00000;
        repeat (3) begin
            step(cf, ifr);
            chk("stall_ctrl_ready", last_cr, 0);
        end
        in_v = 5'b00100; in_d[2] = 11'h155;
        step(cf, ifr);
        chk("stall_ctrl_ready_go", last_cr, 1);
        chk("stall_out_data", out_data, 11'h155);
        cv = 1'b0; in_v = 5'b0;
        step(cf, ifr);

        // Backpressure hold, then drain and refill in the same cycle.
        cv = 1'b1; cd = 3'd0; in_v = 5'b00001; in_d[0] = 11'h7FF;
        step(cf, ifr);
        ordy = 1'b0; cd = 3'd1; in_v = 5'b00011; in_d[1] = 11'h123;
        repeat (4) begin
            step(cf, ifr);
            chk("bp_out_data", out_data, 11'h7FF);
            chk("bp_ctrl_ready", last_cr, 0);
            chk("bp_in_ready", last_ir, 0);
        end
        ordy = 1'b1;
        step(cf, ifr);
        chk("bp_refill_data", out_data, 11'h123);
        chk("bp_refill_valid", out_valid, 1);
        cv = 1'b0; in_v = 5'b0;
        step(cf, ifr);

        // Reserved selector.
        cv = 1'b1; cd = 3'd6; in_v = 5'h1f;
        step(cf, ifr);
        chk("rsv_ctrl_ready", last_cr, 1);
        chk("rsv_in_ready", last_ir, 0);
        chk("rsv_out_valid", out_valid, 0);
`ifdef ROUTERMERGE_CTRL_ERR_EN
        chk("rsv_ctrl_err", ctrl_err, 1);
`endif
        cv = 1'b0; in_v = 5'b0;
        step(cf, ifr);

        // Reset while a flit is held.
        cv = 1'b1; cd = 3'd3; in_v = 5'b01000; in_d[3] = 11'h2AA; ordy = 1'b0;
        step(cf, ifr);
        chk("mid_loaded", out_data, 11'h2AA);
        RESET = 1'b1; ordy = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_ctrl_ready", ctrl_ready, 0);
        chk("mid_rst_in_ready", in_r, 0);
        @(posedge CLK);
        #1;
        chk("mid_rst_hold_valid", out_valid, 0);
        RESET = 1'b0;
        m_valid = 1'b0; m_data = '0; m_err = 1'b0;
        cv = 1'b0; in_v = 5'b0;
        step(cf, ifr);

        // Random stress with counting sources and scoreboard.
        for (int n = 0; n < 5; n++) cnt[n] = 0;
        for (int i = 0; i < 1000; i++) begin
            tok[i] = int'($urandom_range(0, 3));
            sb.push_back({3'(tok[i]), 8'(cnt[tok[i]])});
            cnt[tok[i]]++;
        end
        for (int n = 0; n < 5; n++) cnt[n] = 0;
        sb_on = 1'b1; idx = 0; cycles = 0;
        while (idx < 1000 && cycles < 20000) begin
            cv = ($urandom_range(0, 9) < 8);
            cd = 3'(tok[idx]);
            for (int n = 0; n < 5; n++) begin
                in_v[n] = ($urandom_range(0, 9) < 7);
                in_d[n] = {3'(n), 8'(cnt[n])};
            end
            ordy = ($urandom_range(0, 3) != 0);
            step(cf, ifr);
            if (cf) idx++;
            for (int n = 0; n < 5; n++) if (ifr[n]) cnt[n]++;
            cycles++;
        end
        if (idx < 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL stress_timeout actual=%0d tokens required=1000", idx);
        end
        cv = 1'b0; in_v = 5'b0; ordy = 1'b1;
        repeat (3) step(cf, ifr);
        chk("stress_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
